imem_loader: RTL and testbench

//   Boot-time writer for instruction memory: takes a byte stream over a valid/ready handshake,

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// frame-format constants and the length range check.
package imem_loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  // A frame is loadable only if it carries at least one word and fits the memory.
  function automatic logic len_valid(input logic [LEN_W-1:0] n, input int unsigned capacity);
    return (n != '0) && (32'(n) <= capacity);
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Byte-lane counter and little-endian word assembly register for the boot loader.
// word_full_o flags the byte that completes the current word.
module imem_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d;

  // NOTE: every variable gets its default first so no path through the block leaves it unassigned (no latch).
  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clear_i) begin
      lane_d = '0;
      word_d = '0;
    end else if (byte_en_i) begin
      word_d[8*lane_q +: 8] = byte_i;
      lane_d                = lane_q + LANE_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = byte_en_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length-prefixed byte frame -> 32-bit word writes,
// core held until the load completes. Optional trailing XOR checksum: IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned CAPACITY = 1 << ADDR_W;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  index_q, index_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               xfer;
  logic               load_start;
  logic               pack_en;
  logic               word_full;
  logic               last_word;
  logic [WORD_W-1:0]  word;

  assign xfer      = byte_valid & byte_ready;
  assign pack_en   = xfer && (state_q == ST_DATA);
  assign last_word = (32'(index_q) == (32'(len_q) - 32'd1));

  imem_byte_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk         (clk),
    .rst_n       (reset),
    .clear_i     (load_start),
    .byte_en_i   (pack_en),
    .byte_i      (byte_in),
    .word_o      (word),
    .word_full_o (word_full)
  );

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running XOR over every length and payload byte; the checksum byte itself is excluded.
  always_comb begin
    csum_d = csum_q;
    if (load_start) begin
      csum_d = '0;
    end else if (xfer && (state_q != ST_CSUM)) begin
      csum_d = csum_q ^ byte_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    len_d      = len_q;
    load_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN_LO;
          index_d    = '0;
          load_start = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_in;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_in;
          state_d     = len_valid({byte_in, len_q[7:0]}, CAPACITY) ? ST_DATA : ST_ERR;
        end
      end
      ST_DATA: begin
        if (word_full) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end else begin
          index_d = index_q + ADDR_W'(1);
          state_d = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      len_q   <= len_d;
    end
  end

  // Outputs are pure decodes of registered state, so ready never depends on valid.
  assign byte_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign imem_we    = (state_q == ST_WRITE);
  assign imem_waddr = index_q;
  assign imem_wdata = word;
  assign core_hold  = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; the checksum byte is sent only when
// IMEM_LOADER_CSUM_EN is defined for the build.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int WORD_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [WORD_W-1:0] imem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [WORD_W-1:0] wr_data[$];
  logic [31:0]       frame_words[64];
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_flip = 8'h00;
`endif

  imem_loader #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Present one byte after `gap` idle cycles and hold it until the DUT takes it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic accepted;
    int   cycles;
    repeat (gap) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    cycles     = 0;
    forever begin
      accepted = byte_ready;
      tick();
      if (accepted === 1'b1) break;
      cycles++;
      if (cycles > 50) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] n, input int nw, input int max_gap,
                            input int start_after);
    logic [7:0] b;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] csum;
    csum = n[7:0] ^ n[15:8];
`endif
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = frame_words[w][8*k +: 8];
`ifdef IMEM_LOADER_CSUM_EN
        csum ^= b;
`endif
        send_byte(b, $urandom_range(max_gap, 0));
      end
      if (w == start_after) pulse_start();
    end
`ifdef IMEM_LOADER_CSUM_EN
    if (nw > 0) send_byte(csum ^ csum_flip, 0);
`endif
    repeat (3) tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_flags"}, {27'd0, byte_ready, imem_we, core_hold, done, error}, 32'b00100);
    check({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
  endtask

  function automatic logic [31:0] big_word(input int i);
    logic [7:0] v;
    v = 8'(i);
    return {v, 8'hA5, ~v, 8'(i * 7)};
  endfunction

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b1;
    tick();

    // Reset in the middle of a word: no write, every output back to reset value.
    clear_log();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    reset = 1'b0;
    #2;
    check_idle_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("midreset_no_write", 32'(wr_addr.size()), 32'd0);

    // Two-word program, with write latency checked on the first word.
    clear_log();
    pulse_start();
    check("lenlo_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("w0_we_latency", {30'd0, imem_we, byte_ready}, 32'b10);
    check("w0_waddr", 32'(imem_waddr), 32'd0);
    check("w0_wdata", imem_wdata, 32'h0000_0013);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CSUM_EN
    check("pre_csum_not_done", 32'(done), 32'd0);
    send_byte(8'h92, 0);
`endif
    repeat (2) tick();
    check("prog2_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("prog2_addr1", 32'(wr_addr[1]), 32'd1);
      check("prog2_data1", wr_data[1], 32'h0010_0093);
    end
    check("prog2_status", {29'd0, core_hold, done, error}, 32'b010);

    // Start with a coincident byte in DONE: byte is not taken, done clears.
    clear_log();
    byte_in    = 8'h02;
    byte_valid = 1'b1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    byte_valid = 1'b0;
    check("restart_status", {29'd0, byte_ready, done, error}, 32'b100);
    frame_words[0] = 32'h0000_0013;
    frame_words[1] = 32'h0010_0093;
    send_frame(16'd2, 2, 0, -1);
    check("reload_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("reload_data0", wr_data[0], 32'h0000_0013);
      check("reload_data1", wr_data[1], 32'h0010_0093);
    end
    check("reload_done", 32'(done), 32'd1);

    // Bad lengths: zero and one over capacity.
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("len0_status", {28'd0, byte_ready, core_hold, done, error}, 32'b0101);
    pulse_start();
    check("err_cleared", 32'(error), 32'd0);
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    check("len65_status", {28'd0, byte_ready, core_hold, done, error}, 32'b0101);
    repeat (3) tick();
    check("badlen_no_write", 32'(wr_addr.size()), 32'd0);

    // Random gaps, held bytes during WRITE and an ignored mid-load start.
    clear_log();
    frame_words[0] = 32'hDEAD_BEEF;
    frame_words[1] = 32'h0123_4567;
    frame_words[2] = 32'h8000_00FF;
    pulse_start();
    send_frame(16'd3, 3, 3, 0);
    check("gap_nwrites", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      check("gap_data0", wr_data[0], 32'hDEAD_BEEF);
      check("gap_data1", wr_data[1], 32'h0123_4567);
      check("gap_addr2", 32'(wr_addr[2]), 32'd2);
      check("gap_data2", wr_data[2], 32'h8000_00FF);
    end
    check("gap_done", {30'd0, done, error}, 32'b10);

    // Full-capacity frame.
    clear_log();
    for (int i = 0; i < 64; i++) frame_words[i] = big_word(i);
    pulse_start();
    send_frame(16'd64, 64, 0, -1);
    check("full_nwrites", 32'(wr_addr.size()), 32'd64);
    if (wr_addr.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        check($sformatf("full_addr%0d", i), 32'(wr_addr[i]), 32'(i));
        check($sformatf("full_data%0d", i), wr_data[i], big_word(i));
      end
    end
    check("full_status", {29'd0, core_hold, done, error}, 32'b010);

    clear_log();
    frame_words[0] = 32'h0000_0013;
    frame_words[1] = 32'h0010_0093;
    pulse_start();
    send_frame(16'd2, 2, 0, -1);
    check("after_full_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) check("after_full_addr0", 32'(wr_addr[0]), 32'd0);

`ifdef IMEM_LOADER_CSUM_EN
    // Wrong checksum byte: words are written but the load ends in ERR.
    clear_log();
    csum_flip = 8'h5A;
    pulse_start();
    send_frame(16'd2, 2, 0, -1);
    csum_flip = 8'h00;
    check("badcsum_nwrites", 32'(wr_addr.size()), 32'd2);
    check("badcsum_status", {29'd0, core_hold, done, error}, 32'b101);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
